// File: rtl/stream_xor_cipher_if.sv
// Valid/ready word stream with packet framing, used on both sides of stream_xor_cipher.
// The master drives valid/data/last and the slave drives ready.
interface stream_xor_cipher_if #(
    parameter int unsigned DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/stream_xor_cipher.sv
// Streaming XOR cipher: each accepted word is XORed with a Galois-LFSR keystream seeded
// from the loaded key. The keystream restarts at every packet boundary; encrypt == decrypt.
module stream_xor_cipher #(
    parameter int unsigned       DATA_W = 8,
    parameter logic [DATA_W-1:0] TAPS   = 8'hB8,
    parameter int unsigned       CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_load,
    input  logic [DATA_W-1:0]   key_in,
    stream_xor_cipher_if.slave  in_if,
    stream_xor_cipher_if.master out_if,
    output logic                keyed,
    output logic [CNT_W-1:0]    word_cnt
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] ks_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              out_last_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [DATA_W-1:0] seed;
    logic [DATA_W-1:0] ks_next;
    logic              in_ready;
    logic              accept;

    // A zero key would lock the LFSR at zero, so it is replaced by all-ones.
    assign seed    = (key_in == '0) ? '1 : key_in;
    assign ks_next = (ks_q >> 1) ^ (ks_q[0] ? TAPS : '0);

    assign in_ready = (state_q == StRun) & ~key_load & (~out_valid_q | out_if.ready);
    assign accept   = in_if.valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            key_q       <= '0;
            ks_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            // Reseeding leaves any pending output word to drain normally.
            if (key_load) begin
                key_q   <= seed;
                ks_q    <= seed;
                cnt_q   <= '0;
                state_q <= StRun;
            end else if (accept) begin
                ks_q  <= in_if.last ? key_q : ks_next;
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (accept) begin
                out_data_q  <= in_if.data ^ ks_q;
                out_last_q  <= in_if.last;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_if.ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = out_data_q;
    assign out_if.last  = out_last_q;
    assign keyed        = (state_q == StRun);
    assign word_cnt     = cnt_q;

endmodule
